// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths, the entry record and small helpers for the instruction fetch queue.
// The optional same-cycle bypass is enabled with IFQ_BYPASS_EN (see inst_fetch_queue.sv).
package inst_fetch_queue_pkg;

  localparam int SINGLE_WORD = 32;
  localparam int EXCCODE_W   = 5;
  localparam int INST_NUM    = 4;
  localparam int ISSUE_NUM   = 2;
  localparam logic [SINGLE_WORD-1:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [SINGLE_WORD-1:0] inst;
    logic [SINGLE_WORD-1:0] pc;
    logic                   has_exc;
    logic [EXCCODE_W-1:0]   exc_code;
    logic                   pred_take;
    logic [SINGLE_WORD-1:0] pred_dest;
  } ifq_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-group input bundle and decode-side output bundle of the instruction fetch queue.
// Handshake: a group transfers on a cycle with SCT_valid_i && IFQ_allowin_w_o; output slot j
// transfers on a cycle with IFQ_valid_o[j] && ID_allowin_w_i; nothing transfers while a flush input is high.
interface inst_fetch_queue_if #(parameter int DEPTH = 16);
  localparam int PTR_W = $clog2(DEPTH);

  logic         SCT_valid_i;
  logic         SCT_isCanceled_i;
  logic [31:0]  SCT_VAddr_i;
  logic [3:0]   SCT_originEnable_i;
  logic [127:0] inst_rdata_i;
  logic         SCT_hasException_i;
  logic [4:0]   SCT_ExcCode_i;
  logic [3:0]   SCT_PHT_predTake_p_i;
  logic [127:0] SCT_predDest_p_i;
  logic         BSC_needCancel_w_i;
  logic         CP0_excOccur_w_i;
  logic         IFQ_allowin_w_o;
  logic         ID_allowin_w_i;
  logic [1:0]   IFQ_valid_o;
  logic [63:0]  IFQ_inst_o;
  logic [63:0]  IFQ_VAddr_o;
  logic [63:0]  IFQ_predDest_o;
  logic [1:0]   IFQ_hasException_o;
  logic [1:0]   IFQ_predTake_o;
  logic [9:0]   IFQ_ExcCode_o;
  logic [PTR_W:0] IFQ_count_o;

  modport master (
    output SCT_valid_i, SCT_isCanceled_i, SCT_VAddr_i, SCT_originEnable_i, inst_rdata_i,
           SCT_hasException_i, SCT_ExcCode_i, SCT_PHT_predTake_p_i, SCT_predDest_p_i,
           BSC_needCancel_w_i, CP0_excOccur_w_i, ID_allowin_w_i,
    input  IFQ_allowin_w_o, IFQ_valid_o, IFQ_inst_o, IFQ_VAddr_o, IFQ_predDest_o,
           IFQ_hasException_o, IFQ_predTake_o, IFQ_ExcCode_o, IFQ_count_o
  );

  modport slave (
    input  SCT_valid_i, SCT_isCanceled_i, SCT_VAddr_i, SCT_originEnable_i, inst_rdata_i,
           SCT_hasException_i, SCT_ExcCode_i, SCT_PHT_predTake_p_i, SCT_predDest_p_i,
           BSC_needCancel_w_i, CP0_excOccur_w_i, ID_allowin_w_i,
    output IFQ_allowin_w_o, IFQ_valid_o, IFQ_inst_o, IFQ_VAddr_o, IFQ_predDest_o,
           IFQ_hasException_o, IFQ_predTake_o, IFQ_ExcCode_o, IFQ_count_o
  );
endinterface

// File: rtl/inst_fetch_queue_compact.sv
// ifq_compact: packs the enabled slots of a fetch group into ascending entries and counts them.
// An excepting group collapses to one nop entry built from its lowest enabled slot.
module ifq_compact
  import inst_fetch_queue_pkg::*;
(
  input  logic [27:0]          vaddr_hi,
  input  logic [3:0]           enable,
  input  logic [127:0]         rdata,
  input  logic                 has_exc,
  input  logic [4:0]           exc_code,
  input  logic [3:0]           pred_take,
  input  logic [127:0]         pred_dest,
  output ifq_entry_t [3:0]     ent,
  output logic [2:0]           num
);

  ifq_entry_t slot;
  logic [2:0] fill;

  always_comb begin
    ent  = '0;
    num  = '0;
    slot = '0;
    fill = '0;
    for (int k = 0; k < INST_NUM; k++) begin
      if (enable[k]) begin
        slot.inst      = rdata[32*k +: 32];
        slot.pc        = {vaddr_hi, 2'(k), 2'b00};
        slot.has_exc   = 1'b0;
        slot.exc_code  = '0;
        slot.pred_take = pred_take[k];
        slot.pred_dest = pred_dest[32*k +: 32];
        ent[fill[1:0]] = slot;
        fill           = fill + 3'd1;
      end
    end
    num = fill;
    // Entry 0 already holds the lowest enabled slot, so it becomes the exception carrier.
    if (has_exc && fill != 3'd0) begin
      ent[0].inst     = NOP_INST;
      ent[0].has_exc  = 1'b1;
      ent[0].exc_code = exc_code;
      ent[1]          = '0;
      ent[2]          = '0;
      ent[3]          = '0;
      num             = 3'd1;
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Circular instruction queue between the 4-wide fetch stage and 2-wide decode.
// Define IFQ_BYPASS_EN to let an empty queue forward incoming entries to decode in the same cycle.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);

  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  ifq_entry_t [3:0] in_ent;
  ifq_entry_t [3:0] wr_ent;
  ifq_entry_t [1:0] out_ent;
  logic [2:0]       in_num, wr_num;
  logic [1:0]       stored_valid, out_valid, pop_num;
  logic             flush, allowin, push;

  ifq_compact u_compact (
    .vaddr_hi  (bus.SCT_VAddr_i[31:4]),
    .enable    (bus.SCT_originEnable_i),
    .rdata     (bus.inst_rdata_i),
    .has_exc   (bus.SCT_hasException_i),
    .exc_code  (bus.SCT_ExcCode_i),
    .pred_take (bus.SCT_PHT_predTake_p_i),
    .pred_dest (bus.SCT_predDest_p_i),
    .ent       (in_ent),
    .num       (in_num)
  );

  assign flush   = bus.BSC_needCancel_w_i || bus.CP0_excOccur_w_i;
  // Conservative: room for a full group is judged on current occupancy only.
  assign allowin = count <= (PTR_W+1)'(DEPTH - INST_NUM);
  assign push    = bus.SCT_valid_i && allowin && !bus.SCT_isCanceled_i && !flush;
  assign stored_valid = {count > (PTR_W+1)'(1), count != '0};
  assign pop_num = bus.ID_allowin_w_i ? popcount2(stored_valid) : 2'd0;

`ifdef IFQ_BYPASS_EN
  logic [2:0] byp_num;

  always_comb begin
    out_valid  = stored_valid;
    out_ent[0] = stored_valid[0] ? mem[head] : '0;
    out_ent[1] = stored_valid[1] ? mem[head + PTR_W'(1)] : '0;
    byp_num    = '0;
    wr_num     = push ? in_num : 3'd0;
    wr_ent     = in_ent;
    if (push && count == '0) begin
      out_valid  = {in_num >= 3'd2, in_num >= 3'd1};
      out_ent[0] = (in_num >= 3'd1) ? in_ent[0] : '0;
      out_ent[1] = (in_num >= 3'd2) ? in_ent[1] : '0;
      if (bus.ID_allowin_w_i) begin
        byp_num = (in_num > 3'd2) ? 3'd2 : in_num;
        wr_num  = in_num - byp_num;
        for (int i = 0; i < INST_NUM; i++)
          wr_ent[i] = (i + int'(byp_num) < INST_NUM) ? in_ent[2'(i + int'(byp_num))] : '0;
      end
    end
  end
`else
  always_comb begin
    out_valid  = stored_valid;
    out_ent[0] = stored_valid[0] ? mem[head] : '0;
    out_ent[1] = stored_valid[1] ? mem[head + PTR_W'(1)] : '0;
    wr_num     = push ? in_num : 3'd0;
    wr_ent     = in_ent;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_num);
      tail  <= tail + PTR_W'(wr_num);
      count <= count + (PTR_W+1)'(wr_num) - (PTR_W+1)'(pop_num);
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst && !flush) begin
      for (int i = 0; i < INST_NUM; i++)
        if (3'(i) < wr_num) mem[tail + PTR_W'(i)] <= wr_ent[i];
    end
  end

  assign bus.IFQ_allowin_w_o = allowin;
  assign bus.IFQ_valid_o     = out_valid;
  assign bus.IFQ_count_o     = count;

  for (genvar j = 0; j < ISSUE_NUM; j++) begin : g_out
    assign bus.IFQ_inst_o[32*j +: 32]     = out_ent[j].inst;
    assign bus.IFQ_VAddr_o[32*j +: 32]    = out_ent[j].pc;
    assign bus.IFQ_predDest_o[32*j +: 32] = out_ent[j].pred_dest;
    assign bus.IFQ_hasException_o[j]      = out_ent[j].has_exc;
    assign bus.IFQ_predTake_o[j]          = out_ent[j].pred_take;
    assign bus.IFQ_ExcCode_o[5*j +: 5]    = out_ent[j].exc_code;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: expected entries are queued as groups are issued and
// a monitor checks every entry handed to decode, in order.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int EW    = $bits(ifq_entry_t);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  inst_fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_e, exp_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic expect_ent(input logic [31:0] inst, input logic [31:0] pc, input logic exc,
                            input logic [4:0] code, input logic take, input logic [31:0] dest);
    exp_q.push_back({inst, pc, exc, code, take, dest});
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.SCT_valid_i          = 1'b0;
    bus.SCT_isCanceled_i     = 1'b0;
    bus.SCT_VAddr_i          = '0;
    bus.SCT_originEnable_i   = '0;
    bus.inst_rdata_i         = '0;
    bus.SCT_hasException_i   = 1'b0;
    bus.SCT_ExcCode_i        = '0;
    bus.SCT_PHT_predTake_p_i = '0;
    bus.SCT_predDest_p_i     = '0;
    bus.BSC_needCancel_w_i   = 1'b0;
    bus.CP0_excOccur_w_i     = 1'b0;
  endtask

  // Slot k carries inst base+k and predicted destination 0x8000_0000+base+k.
  task automatic drive_group(input logic [31:0] va, input logic [3:0] en, input logic [31:0] base,
                             input logic exc, input logic [4:0] code, input logic [3:0] take);
    bus.SCT_valid_i          = 1'b1;
    bus.SCT_VAddr_i          = va;
    bus.SCT_originEnable_i   = en;
    bus.SCT_hasException_i   = exc;
    bus.SCT_ExcCode_i        = code;
    bus.SCT_PHT_predTake_p_i = take;
    for (int k = 0; k < 4; k++) begin
      bus.inst_rdata_i[32*k +: 32]     = base + 32'(k);
      bus.SCT_predDest_p_i[32*k +: 32] = 32'h8000_0000 + base + 32'(k);
    end
  endtask

  task automatic send(input logic [31:0] va, input logic [3:0] en, input logic [31:0] base,
                      input logic exc, input logic [4:0] code, input logic [3:0] take);
    drive_group(va, en, base, exc, code, take);
    next();
    bus.SCT_valid_i        = 1'b0;
    bus.SCT_hasException_i = 1'b0;
  endtask

  task automatic fill4(input logic [31:0] va, input logic [31:0] base);
    for (int k = 0; k < 4; k++)
      expect_ent(base + 32'(k), va + 32'(4*k), 1'b0, 5'h0, 1'b0, 32'h8000_0000 + base + 32'(k));
    send(va, 4'hF, base, 1'b0, 5'h0, 4'h0);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (bus.IFQ_count_o != '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_count"}, 32'(bus.IFQ_count_o), 32'd0);
    chk({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every slot decode consumes is checked against the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.SCT_valid_i && !bus.IFQ_allowin_w_o) begin
        errors++;
        $display("FAIL protocol_valid_without_allowin count=%0d", bus.IFQ_count_o);
      end
      for (int j = 0; j < 2; j++) begin
        got_e = {bus.IFQ_inst_o[32*j +: 32], bus.IFQ_VAddr_o[32*j +: 32], bus.IFQ_hasException_o[j],
                 bus.IFQ_ExcCode_o[5*j +: 5], bus.IFQ_predTake_o[j], bus.IFQ_predDest_o[32*j +: 32]};
        if (!bus.IFQ_valid_o[j]) begin
          checks++;
          if (got_e !== '0) begin
            errors++;
            $display("FAIL idle_slot%0d_zero got=%h exp=0", j, got_e);
          end
        end else if (bus.ID_allowin_w_i && !bus.BSC_needCancel_w_i && !bus.CP0_excOccur_w_i) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected slot%0d got=%h exp=none", j, got_e);
          end else begin
            exp_e = exp_q.pop_front();
            if (got_e !== exp_e) begin
              errors++;
              $display("FAIL out_entry slot%0d got=%h exp=%h", j, got_e, exp_e);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    bus.ID_allowin_w_i = 1'b0;
    rst = 1'b0;
    repeat (3) next();
    @(negedge clk);
    chk("reset_count", 32'(bus.IFQ_count_o), 32'd0);
    chk("reset_valid", 32'(bus.IFQ_valid_o), 32'd0);
    chk("reset_allowin", 32'(bus.IFQ_allowin_w_o), 32'd1);
    chk("reset_exccode", 32'(bus.IFQ_ExcCode_o), 32'd0);
    next();
    rst = 1'b1;

    // Full group, decode always ready.
    bus.ID_allowin_w_i = 1'b1;
    expect_ent(32'hA0, 32'h1000, 1'b0, 5'h0, 1'b0, 32'h8000_00A0);
    expect_ent(32'hA1, 32'h1004, 1'b0, 5'h0, 1'b1, 32'h8000_00A1);
    expect_ent(32'hA2, 32'h1008, 1'b0, 5'h0, 1'b0, 32'h8000_00A2);
    expect_ent(32'hA3, 32'h100C, 1'b0, 5'h0, 1'b0, 32'h8000_00A3);
    send(32'h1000, 4'hF, 32'hA0, 1'b0, 5'h0, 4'b0010);
    @(negedge clk);
    chk("t1_valid_after_push", 32'(bus.IFQ_valid_o), 32'd3);
    wait_empty("t1");

    // Sparse mask 1010 skips the holes.
    next();
    expect_ent(32'hB1, 32'h2004, 1'b0, 5'h0, 1'b0, 32'h8000_00B1);
    expect_ent(32'hB3, 32'h200C, 1'b0, 5'h0, 1'b1, 32'h8000_00B3);
    send(32'h2000, 4'b1010, 32'hB0, 1'b0, 5'h0, 4'b1000);
    wait_empty("t2");

    // Fill to 12 / 13, allowin boundary, pop two, refill across the index wrap.
    next();
    bus.ID_allowin_w_i = 1'b0;
    fill4(32'h3000, 32'hC0);
    fill4(32'h3010, 32'hC4);
    fill4(32'h3020, 32'hC8);
    @(negedge clk);
    chk("t3_count12", 32'(bus.IFQ_count_o), 32'd12);
    chk("t3_allowin_at12", 32'(bus.IFQ_allowin_w_o), 32'd1);
    next();
    expect_ent(32'hCC, 32'h3030, 1'b0, 5'h0, 1'b0, 32'h8000_00CC);
    send(32'h3030, 4'b0001, 32'hCC, 1'b0, 5'h0, 4'h0);
    @(negedge clk);
    chk("t3_count13", 32'(bus.IFQ_count_o), 32'd13);
    chk("t3_allowin_at13", 32'(bus.IFQ_allowin_w_o), 32'd0);
    next();
    bus.ID_allowin_w_i = 1'b1;
    next();
    bus.ID_allowin_w_i = 1'b0;
    @(negedge clk);
    chk("t3_count_after_pop", 32'(bus.IFQ_count_o), 32'd11);
    chk("t3_allowin_after_pop", 32'(bus.IFQ_allowin_w_o), 32'd1);
    next();
    fill4(32'h3040, 32'hD0);
    @(negedge clk);
    chk("t3_count15", 32'(bus.IFQ_count_o), 32'd15);
    next();
    bus.ID_allowin_w_i = 1'b1;
    wait_empty("t3");

    // Exception group collapses to one nop entry for slot 1.
    next();
    expect_ent(32'h0, 32'h4004, 1'b1, 5'h04, 1'b1, 32'h8000_00E1);
    send(32'h4000, 4'b0110, 32'hE0, 1'b1, 5'h04, 4'b0010);
    wait_empty("t4");

    // Branch flush with a same-cycle push and pop.
    next();
    bus.ID_allowin_w_i = 1'b0;
    fill4(32'h5000, 32'hF0);
    fill4(32'h5010, 32'hF4);
    expect_ent(32'hF8, 32'h5020, 1'b0, 5'h0, 1'b0, 32'h8000_00F8);
    send(32'h5020, 4'b0001, 32'hF8, 1'b0, 5'h0, 4'h0);
    @(negedge clk);
    chk("t5_count9", 32'(bus.IFQ_count_o), 32'd9);
    next();
    bus.BSC_needCancel_w_i = 1'b1;
    bus.ID_allowin_w_i     = 1'b1;
    exp_q.delete();
    send(32'h5030, 4'hF, 32'h60, 1'b0, 5'h0, 4'h0);
    bus.BSC_needCancel_w_i = 1'b0;
    @(negedge clk);
    chk("t5_flush_count", 32'(bus.IFQ_count_o), 32'd0);
    chk("t5_flush_valid", 32'(bus.IFQ_valid_o), 32'd0);

    // Exception-path flush.
    next();
    bus.ID_allowin_w_i = 1'b0;
    fill4(32'h5040, 32'h70);
    bus.CP0_excOccur_w_i = 1'b1;
    exp_q.delete();
    next();
    bus.CP0_excOccur_w_i = 1'b0;
    @(negedge clk);
    chk("cp0_flush_count", 32'(bus.IFQ_count_o), 32'd0);

    // Upstream-cancelled group is dropped.
    next();
    expect_ent(32'h10, 32'h6000, 1'b0, 5'h0, 1'b0, 32'h8000_0010);
    expect_ent(32'h11, 32'h6004, 1'b0, 5'h0, 1'b0, 32'h8000_0011);
    send(32'h6000, 4'b0011, 32'h10, 1'b0, 5'h0, 4'h0);
    bus.SCT_isCanceled_i = 1'b1;
    send(32'h6010, 4'hF, 32'h20, 1'b0, 5'h0, 4'h0);
    bus.SCT_isCanceled_i = 1'b0;
    @(negedge clk);
    chk("t6_cancel_count", 32'(bus.IFQ_count_o), 32'd2);
    next();
    bus.ID_allowin_w_i = 1'b1;
    wait_empty("t6");

    // Push into an empty queue with decode ready: latency depends on the bypass build.
    next();
    expect_ent(32'h30, 32'h7000, 1'b0, 5'h0, 1'b0, 32'h8000_0030);
    expect_ent(32'h31, 32'h7004, 1'b0, 5'h0, 1'b1, 32'h8000_0031);
    drive_group(32'h7000, 4'b0011, 32'h30, 1'b0, 5'h0, 4'b0010);
    @(negedge clk);
`ifdef IFQ_BYPASS_EN
    chk("t7_same_cycle_valid", 32'(bus.IFQ_valid_o), 32'd3);
`else
    chk("t7_same_cycle_valid", 32'(bus.IFQ_valid_o), 32'd0);
`endif
    next();
    bus.SCT_valid_i = 1'b0;
    @(negedge clk);
`ifdef IFQ_BYPASS_EN
    chk("t7_count_after", 32'(bus.IFQ_count_o), 32'd0);
`else
    chk("t7_count_after", 32'(bus.IFQ_count_o), 32'd2);
`endif
    wait_empty("t7");

    // Reset mid-operation, together with a flush.
    next();
    bus.ID_allowin_w_i = 1'b0;
    fill4(32'h8000, 32'h40);
    rst = 1'b0;
    bus.BSC_needCancel_w_i = 1'b1;
    exp_q.delete();
    next();
    rst = 1'b1;
    bus.BSC_needCancel_w_i = 1'b0;
    @(negedge clk);
    chk("t8_reset_count", 32'(bus.IFQ_count_o), 32'd0);
    chk("t8_reset_valid", 32'(bus.IFQ_valid_o), 32'd0);
    chk("t8_reset_allowin", 32'(bus.IFQ_allowin_w_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
